// File: rtl/recog_pkg.sv
// Shared defaults, the per-edge action type and the pattern-length clamp for the
// Moore pattern recognizer.
package recog_pkg;

  localparam int unsigned SymWDef  = 2;
  localparam int unsigned LenDef   = 3;
  localparam int unsigned CntWDef  = 8;
  // Symbol 0 sits in the low bits: the default pattern is 11, 01, 10.
  localparam logic [5:0]  RstPatDef  = {2'b10, 2'b01, 2'b11};
  localparam int unsigned RstPlenDef = 3;

  typedef enum logic [1:0] {
    ActHold,
    ActLoad,
    ActAccept
  } recog_act_e;

  // Lengths of 0 or beyond the storage depth fall back to the full depth.
  function automatic int unsigned clamp_plen(input int unsigned plen, input int unsigned len);
    return ((plen == 0) || (plen > len)) ? len : plen;
  endfunction

endpackage

// File: rtl/pattern_prefix_match.sv
// Combinational KMP step: longest pattern prefix that is a suffix of the valid
// history followed by the incoming symbol.
module pattern_prefix_match #(
  parameter int unsigned SYM_W = 2,
  parameter int unsigned LEN   = 3,
  localparam int unsigned PW   = $clog2(LEN + 1),
  localparam int unsigned HW   = (LEN > 1) ? LEN - 1 : 1
) (
  input  logic [HW*SYM_W-1:0]  hist_i,
  input  logic [PW-1:0]        hcnt_i,
  input  logic [SYM_W-1:0]     x_i,
  input  logic [LEN*SYM_W-1:0] pattern_i,
  input  logic [PW-1:0]        plen_i,
  output logic [PW-1:0]        k_o
);

  // hit[k-1]: the last k candidate symbols equal pattern symbols 0..k-1.
  logic [LEN-1:0] hit;

  always_comb begin
    hit = '0;
    for (int k = 1; k <= LEN; k++) begin
      hit[k-1] = (k <= int'(plen_i)) && (k <= int'(hcnt_i) + 1) &&
                 (pattern_i[(k-1)*SYM_W +: SYM_W] == x_i);
      // hist entry j (0 = most recent) lines up with pattern symbol k-2-j.
      for (int j = 0; j < LEN - 1; j++) begin
        if (j <= k - 2) begin
          hit[k-1] = hit[k-1] &&
                     (hist_i[j*SYM_W +: SYM_W] ==
                      pattern_i[((j <= k - 2) ? (k - 2 - j) : 0)*SYM_W +: SYM_W]);
        end
      end
    end
  end

  always_comb begin
    k_o = '0;
    for (int k = 1; k <= LEN; k++) begin
      if (hit[k-1]) begin
        k_o = PW'(k);
      end
    end
  end

endmodule

// File: rtl/moore_pattern_recognizer.sv
// Moore sequence recognizer with runtime pattern load, overlap control and a
// saturating match counter. Z is a registered decode of state == plen.
module moore_pattern_recognizer
  import recog_pkg::*;
#(
  parameter int unsigned         SYM_W    = SymWDef,
  parameter int unsigned         LEN      = LenDef,
  parameter int unsigned         CNT_W    = CntWDef,
  parameter logic [LEN*SYM_W-1:0] RST_PAT = RstPatDef,
  parameter int unsigned         RST_PLEN = RstPlenDef,
  localparam int unsigned        PW       = $clog2(LEN + 1),
  localparam int unsigned        HW       = (LEN > 1) ? LEN - 1 : 1
) (
  input  logic                 Ck,
  input  logic                 reset_,
  input  logic [SYM_W-1:0]     X,
  input  logic                 valid,
  input  logic                 overlap,
  input  logic                 load,
  input  logic [LEN*SYM_W-1:0] pat_in,
  input  logic [PW-1:0]        plen_in,
  input  logic                 clr_cnt,
  output logic                 Z,
  output logic [PW-1:0]        state,
  output logic [CNT_W-1:0]     match_cnt
);

  logic [LEN*SYM_W-1:0] pattern_q, pattern_d;
  logic [PW-1:0]        plen_q, plen_d;
  logic [HW*SYM_W-1:0]  hist_q, hist_d, hist_shift;
  logic [PW-1:0]        hcnt_q, hcnt_d, hcnt_inc;
  logic [PW-1:0]        state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 z_q, z_d;
  logic [PW-1:0]        k;
  logic                 match;
  recog_act_e           act;

  pattern_prefix_match #(
    .SYM_W (SYM_W),
    .LEN   (LEN)
  ) u_prefix_match (
    .hist_i    (hist_q),
    .hcnt_i    (hcnt_q),
    .x_i       (X),
    .pattern_i (pattern_q),
    .plen_i    (plen_q),
    .k_o       (k)
  );

  // Newest symbol enters at entry 0; the oldest falls off the top.
  always_comb begin
    hist_shift = hist_q;
    for (int j = HW - 1; j >= 1; j--) begin
      hist_shift[j*SYM_W +: SYM_W] = hist_q[(j-1)*SYM_W +: SYM_W];
    end
    hist_shift[0 +: SYM_W] = X;
    hcnt_inc = (hcnt_q >= PW'(LEN - 1)) ? PW'(LEN - 1) : hcnt_q + 1'b1;
  end

  always_comb begin
    if (load) begin
      act = ActLoad;
    end else if (valid) begin
      act = ActAccept;
    end else begin
      act = ActHold;
    end
  end

  always_comb begin
    pattern_d = pattern_q;
    plen_d    = plen_q;
    hist_d    = hist_q;
    hcnt_d    = hcnt_q;
    state_d   = state_q;
    match     = 1'b0;
    unique case (act)
      ActLoad: begin
        pattern_d = pat_in;
        plen_d    = PW'(clamp_plen(32'(plen_in), LEN));
        hcnt_d    = '0;
        state_d   = '0;
      end
      ActAccept: begin
        if (k == plen_q) begin
          match   = 1'b1;
          state_d = plen_q;
          if (overlap) begin
            hist_d = hist_shift;
            hcnt_d = hcnt_inc;
          end else begin
            hcnt_d = '0;
          end
        end else begin
          hist_d  = hist_shift;
          hcnt_d  = hcnt_inc;
          state_d = k;
        end
      end
      ActHold: ;
      default: ;
    endcase
  end

  // A clear and a match on the same edge leave exactly one match counted.
  always_comb begin
    cnt_d = clr_cnt ? '0 : cnt_q;
    if (match && (cnt_d != '1)) begin
      cnt_d = cnt_d + 1'b1;
    end
    z_d = (state_d == plen_d);
  end

  always_ff @(posedge Ck or negedge reset_) begin
    if (!reset_) begin
      pattern_q <= RST_PAT;
      plen_q    <= PW'(clamp_plen(RST_PLEN, LEN));
      hist_q    <= '0;
      hcnt_q    <= '0;
      state_q   <= '0;
      cnt_q     <= '0;
      z_q       <= 1'b0;
    end else begin
      pattern_q <= pattern_d;
      plen_q    <= plen_d;
      hist_q    <= hist_d;
      hcnt_q    <= hcnt_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      z_q       <= z_d;
    end
  end

  assign Z         = z_q;
  assign state     = state_q;
  assign match_cnt = cnt_q;

endmodule

// File: tb/tb_moore_pattern_recognizer.sv
// Directed bench for moore_pattern_recognizer (LEN=3, SYM_W=2, CNT_W=2 so that
// counter saturation is reachable in a few matches).
module tb_moore_pattern_recognizer;

  logic       Ck;
  logic       reset_;
  logic [1:0] X;
  logic       valid;
  logic       overlap;
  logic       load;
  logic [5:0] pat_in;
  logic [1:0] plen_in;
  logic       clr_cnt;
  logic       Z;
  logic [1:0] state;
  logic [1:0] match_cnt;

  int tests;
  int fails;

  moore_pattern_recognizer #(
    .SYM_W    (2),
    .LEN      (3),
    .CNT_W    (2),
    .RST_PAT  (6'b10_01_11),
    .RST_PLEN (3)
  ) dut (
    .Ck        (Ck),
    .reset_    (reset_),
    .X         (X),
    .valid     (valid),
    .overlap   (overlap),
    .load      (load),
    .pat_in    (pat_in),
    .plen_in   (plen_in),
    .clr_cnt   (clr_cnt),
    .Z         (Z),
    .state     (state),
    .match_cnt (match_cnt)
  );

  initial Ck = 1'b0;
  always #5 Ck = ~Ck;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] st, input logic z,
                         input logic [1:0] cnt);
    chk({tag, ".state"}, 32'(state), 32'(st));
    chk({tag, ".Z"}, 32'(Z), 32'(z));
    chk({tag, ".cnt"}, 32'(match_cnt), 32'(cnt));
  endtask

  task automatic step(input logic [1:0] x, input logic v, input logic clr);
    @(negedge Ck);
    X       = x;
    valid   = v;
    load    = 1'b0;
    clr_cnt = clr;
    @(posedge Ck);
    #1;
  endtask

  task automatic ld(input logic [5:0] pat, input logic [1:0] pl, input logic v,
                    input logic [1:0] x);
    @(negedge Ck);
    load    = 1'b1;
    pat_in  = pat;
    plen_in = pl;
    valid   = v;
    X       = x;
    clr_cnt = 1'b0;
    @(posedge Ck);
    #1;
  endtask

  task automatic do_reset();
    @(negedge Ck);
    valid   = 1'b0;
    load    = 1'b0;
    clr_cnt = 1'b0;
    reset_  = 1'b0;
    #2;
    reset_  = 1'b1;
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    reset_  = 1'b0;
    X       = 2'b00;
    valid   = 1'b0;
    overlap = 1'b1;
    load    = 1'b0;
    pat_in  = 6'b0;
    plen_in = 2'd0;
    clr_cnt = 1'b0;
    #12;
    chk_all("reset", 2'd0, 1'b0, 2'd0);
    @(negedge Ck);
    reset_ = 1'b1;

    // 1: default pattern 11,01,10
    step(2'b00, 1'b1, 1'b0); chk_all("t1.s00", 2'd0, 1'b0, 2'd0);
    step(2'b11, 1'b1, 1'b0); chk_all("t1.s11", 2'd1, 1'b0, 2'd0);
    step(2'b01, 1'b1, 1'b0); chk_all("t1.s01", 2'd2, 1'b0, 2'd0);
    step(2'b10, 1'b1, 1'b0); chk_all("t1.s10", 2'd3, 1'b1, 2'd1);
    step(2'b00, 1'b1, 1'b0); chk_all("t1.s00b", 2'd0, 1'b0, 2'd1);

    // 2: KMP fallback on repeated 11, then back-to-back match
    do_reset();
    step(2'b11, 1'b1, 1'b0); chk_all("t2.a", 2'd1, 1'b0, 2'd0);
    step(2'b11, 1'b1, 1'b0); chk_all("t2.b", 2'd1, 1'b0, 2'd0);
    step(2'b01, 1'b1, 1'b0); chk_all("t2.c", 2'd2, 1'b0, 2'd0);
    step(2'b10, 1'b1, 1'b0); chk_all("t2.d", 2'd3, 1'b1, 2'd1);
    step(2'b11, 1'b1, 1'b0); chk_all("t2.e", 2'd1, 1'b0, 2'd1);
    step(2'b01, 1'b1, 1'b0); chk_all("t2.f", 2'd2, 1'b0, 2'd1);
    step(2'b10, 1'b1, 1'b0); chk_all("t2.g", 2'd3, 1'b1, 2'd2);

    // 3: pattern 11,11 with overlap on then off
    do_reset();
    overlap = 1'b1;
    ld(6'b00_11_11, 2'd2, 1'b0, 2'b00); chk_all("t3.load", 2'd0, 1'b0, 2'd0);
    step(2'b11, 1'b1, 1'b0); chk_all("t3.o1", 2'd1, 1'b0, 2'd0);
    step(2'b11, 1'b1, 1'b0); chk_all("t3.o2", 2'd2, 1'b1, 2'd1);
    step(2'b11, 1'b1, 1'b0); chk_all("t3.o3", 2'd2, 1'b1, 2'd2);
    step(2'b11, 1'b1, 1'b0); chk_all("t3.o4", 2'd2, 1'b1, 2'd3);
    step(2'b00, 1'b0, 1'b1); chk_all("t3.clr", 2'd2, 1'b1, 2'd0);
    overlap = 1'b0;
    ld(6'b00_11_11, 2'd2, 1'b0, 2'b00); chk_all("t3.reload", 2'd0, 1'b0, 2'd0);
    step(2'b11, 1'b1, 1'b0); chk_all("t3.n1", 2'd1, 1'b0, 2'd0);
    step(2'b11, 1'b1, 1'b0); chk_all("t3.n2", 2'd2, 1'b1, 2'd1);
    step(2'b11, 1'b1, 1'b0); chk_all("t3.n3", 2'd1, 1'b0, 2'd1);
    step(2'b11, 1'b1, 1'b0); chk_all("t3.n4", 2'd2, 1'b1, 2'd2);

    // 4: valid gaps are ignored and Z holds while valid is low
    do_reset();
    overlap = 1'b1;
    step(2'b11, 1'b1, 1'b0); chk_all("t4.v1", 2'd1, 1'b0, 2'd0);
    step(2'b00, 1'b0, 1'b0); chk_all("t4.gap1", 2'd1, 1'b0, 2'd0);
    step(2'b01, 1'b0, 1'b0); chk_all("t4.gap2", 2'd1, 1'b0, 2'd0);
    step(2'b01, 1'b1, 1'b0); chk_all("t4.v4", 2'd2, 1'b0, 2'd0);
    step(2'b10, 1'b1, 1'b0); chk_all("t4.v5", 2'd3, 1'b1, 2'd1);
    step(2'b11, 1'b0, 1'b0); chk_all("t4.hold1", 2'd3, 1'b1, 2'd1);
    step(2'b00, 1'b0, 1'b0); chk_all("t4.hold2", 2'd3, 1'b1, 2'd1);

    // 5: load beats valid, plen 0 clamps to 3, counter saturation, clear+match
    do_reset();
    step(2'b11, 1'b1, 1'b0); chk_all("t5.pre", 2'd1, 1'b0, 2'd0);
    ld(6'b10_01_11, 2'd0, 1'b1, 2'b11); chk_all("t5.load", 2'd0, 1'b0, 2'd0);
    for (int m = 1; m <= 4; m++) begin
      step(2'b11, 1'b1, 1'b0); chk_all("t5.m11", 2'd1, 1'b0, (m > 3) ? 2'd3 : 2'(m - 1));
      step(2'b01, 1'b1, 1'b0); chk_all("t5.m01", 2'd2, 1'b0, (m > 3) ? 2'd3 : 2'(m - 1));
      step(2'b10, 1'b1, 1'b0); chk_all("t5.m10", 2'd3, 1'b1, (m >= 3) ? 2'd3 : 2'(m));
    end
    step(2'b11, 1'b1, 1'b0); chk_all("t5.c11", 2'd1, 1'b0, 2'd3);
    step(2'b01, 1'b1, 1'b0); chk_all("t5.c01", 2'd2, 1'b0, 2'd3);
    step(2'b10, 1'b1, 1'b1); chk_all("t5.clrmatch", 2'd3, 1'b1, 2'd1);
    step(2'b00, 1'b1, 1'b1); chk_all("t5.clronly", 2'd0, 1'b0, 2'd0);

    // 6: asynchronous reset mid-sequence
    do_reset();
    step(2'b11, 1'b1, 1'b0);
    step(2'b01, 1'b1, 1'b0);
    step(2'b10, 1'b1, 1'b0); chk_all("t6.match", 2'd3, 1'b1, 2'd1);
    step(2'b11, 1'b1, 1'b0);
    step(2'b01, 1'b1, 1'b0); chk_all("t6.pre", 2'd2, 1'b0, 2'd1);
    @(negedge Ck);
    reset_ = 1'b0;
    #1;
    chk_all("t6.async", 2'd0, 1'b0, 2'd0);
    #1;
    reset_ = 1'b1;
    step(2'b01, 1'b1, 1'b0); chk_all("t6.r01", 2'd0, 1'b0, 2'd0);
    step(2'b10, 1'b1, 1'b0); chk_all("t6.r10", 2'd0, 1'b0, 2'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
